// File: rtl/tft_timing_pkg.sv
// Shared constants and types for the TFT timing receiver.
package tft_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int LOCK_CNT_W   = 4;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/tft_sync_edge.sv
// Polarity normalisation and strobe-gated edge detection for one timing input.
module tft_sync_edge #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  input  logic i_sig,
  output logic o_level,
  output logic o_lead,
  output logic o_trail
);

  logic w_level;
  logic r_prev;

  assign w_level = ACTIVE_LOW ? ~i_sig : i_sig;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
    end else if (i_stb) begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_lead  = i_stb & w_level & ~r_prev;
  assign o_trail = i_stb & ~w_level & r_prev;

endmodule

// File: rtl/tft_timing_rx.sv
// TFT timing receiver: recovers pixel coordinates from HS/VS/DE and locks onto a stable format.
// Optional o_err_cnt format-error counter is enabled by defining TFT_TIMING_RX_ERRCNT_EN.
module tft_timing_rx
  import tft_timing_pkg::*;
#(
  parameter int HS_ACTIVE_LOW = 1,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int CNT_W         = 11,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  output logic [10:0]      o_x,
  output logic [8:0]       o_y,
  output logic             o_valid,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_locked,
  output logic [CNT_W-1:0] o_line_total,
  output logic [CNT_W-1:0] o_frame_lines,
  output logic             o_fmt_err
`ifdef TFT_TIMING_RX_ERRCNT_EN
  ,
  output logic [15:0]      o_err_cnt
`endif
);

  logic w_hs_lvl, w_hs_lead, w_hs_trail;
  logic w_vs_lvl, w_vs_lead, w_vs_trail;
  logic w_de_lvl, w_de_lead, w_de_trail;
  logic w_unused;

  tft_sync_edge #(.ACTIVE_LOW(HS_ACTIVE_LOW != 0)) u_hs_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_stb(i_pix_stb), .i_sig(i_hs),
    .o_level(w_hs_lvl), .o_lead(w_hs_lead), .o_trail(w_hs_trail)
  );

  tft_sync_edge #(.ACTIVE_LOW(VS_ACTIVE_LOW != 0)) u_vs_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_stb(i_pix_stb), .i_sig(i_vs),
    .o_level(w_vs_lvl), .o_lead(w_vs_lead), .o_trail(w_vs_trail)
  );

  tft_sync_edge #(.ACTIVE_LOW(1'b0)) u_de_edge (
    .i_clk(i_clk), .i_rst(i_rst), .i_stb(i_pix_stb), .i_sig(i_de),
    .o_level(w_de_lvl), .o_lead(w_de_lead), .o_trail(w_de_trail)
  );

  assign w_unused = &{1'b0, w_hs_lvl, w_hs_trail, w_vs_lvl, w_vs_trail, w_de_lead};

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt, r_y_cnt;
  logic [CNT_W-1:0] r_line_total, r_frame_lines, r_ref_total;
  logic [10:0]      r_x_cnt, r_last_width;
  logic [10:0]      r_x;
  logic [8:0]       r_y;
  logic             r_valid, r_sof, r_eol, r_sof_pend, r_fmt_err;
  lock_state_t      r_state, w_state_nxt;
  logic [LOCK_CNT_W-1:0] r_match, w_match_nxt;
  logic             w_err;

  logic             w_h_sat;
  logic [CNT_W-1:0] w_line_total_nxt;
  logic [CNT_W-1:0] w_line_total_now;
  logic             w_frame_ok;
  logic             w_lock_break;

  assign w_h_sat          = &r_h_cnt;
  assign w_line_total_nxt = r_h_cnt + 1'b1;
  assign w_line_total_now = w_hs_lead ? w_line_total_nxt : r_line_total;

  // Line/frame measurement and DE position counters; the HS edge that coincides
  // with a VS edge is the first line of the new frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_y_cnt       <= '0;
      r_x_cnt       <= '0;
      r_last_width  <= '0;
      r_line_total  <= '0;
      r_frame_lines <= '0;
      r_ref_total   <= '0;
    end else if (i_pix_stb) begin
      if (w_hs_lead) begin
        r_line_total <= w_line_total_nxt;
        r_h_cnt      <= '0;
      end else if (!w_h_sat) begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end

      if (w_vs_lead) begin
        r_frame_lines <= r_v_cnt;
        r_ref_total   <= w_line_total_now;
        r_v_cnt       <= w_hs_lead ? CNT_W'(1) : '0;
      end else if (w_hs_lead && !(&r_v_cnt)) begin
        r_v_cnt <= r_v_cnt + 1'b1;
      end

      if (w_de_trail) begin
        r_last_width <= r_x_cnt;
        r_x_cnt      <= '0;
      end else if (w_de_lvl && !(&r_x_cnt)) begin
        r_x_cnt <= r_x_cnt + 1'b1;
      end

      if (w_vs_lead) begin
        r_y_cnt <= '0;
      end else if (w_de_trail && !(&r_y_cnt)) begin
        r_y_cnt <= r_y_cnt + 1'b1;
      end
    end
  end

  // Pixel outputs lag the DE sample by one strobe; coordinates hold outside DE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_valid    <= 1'b0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_sof_pend <= 1'b0;
      r_fmt_err  <= 1'b0;
    end else if (i_pix_stb) begin
      r_valid   <= w_de_lvl;
      r_sof     <= w_de_lvl & r_sof_pend;
      r_eol     <= w_de_trail;
      r_fmt_err <= w_err;
      if (w_de_lvl) begin
        r_x <= r_x_cnt;
        r_y <= (r_y_cnt >= CNT_W'(V_ACTIVE - 1)) ? 9'(V_ACTIVE - 1) : r_y_cnt[8:0];
      end
      if (w_vs_lead) begin
        r_sof_pend <= 1'b1;
      end else if (w_de_lvl) begin
        r_sof_pend <= 1'b0;
      end
    end
  end

  assign w_frame_ok = (w_line_total_now == r_ref_total) &&
                      (r_v_cnt == r_frame_lines) &&
                      (r_last_width == 11'(H_ACTIVE)) &&
                      (r_y_cnt == CNT_W'(V_ACTIVE));

  assign w_lock_break = (w_de_trail && (r_x_cnt != 11'(H_ACTIVE))) ||
                        (w_hs_lead && (w_line_total_nxt != r_line_total)) ||
                        (w_vs_lead && (r_v_cnt != r_frame_lines)) ||
                        w_h_sat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SEARCH;
      r_match <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  // Lock FSM: each frame is judged at the VS edge that closes it.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_err       = 1'b0;
    if (i_pix_stb) begin
      case (r_state)
        SEARCH: begin
          if (w_vs_lead) begin
            w_state_nxt = MEASURE;
            w_match_nxt = '0;
          end
        end
        MEASURE: begin
          if (w_vs_lead) begin
            if (w_frame_ok) begin
              w_match_nxt = r_match + 1'b1;
              if (w_match_nxt >= LOCK_CNT_W'(LOCK_FRAMES)) begin
                w_state_nxt = LOCKED;
              end
            end else begin
              w_match_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (w_lock_break) begin
            w_err       = 1'b1;
            w_state_nxt = SEARCH;
            w_match_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = SEARCH;
          w_match_nxt = '0;
        end
      endcase
    end
  end

`ifdef TFT_TIMING_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= '0;
    end else if (w_err && !(&r_err_cnt)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_valid       = r_valid;
  assign o_sof         = r_sof;
  assign o_eol         = r_eol;
  assign o_locked      = (r_state == LOCKED);
  assign o_line_total  = r_line_total;
  assign o_frame_lines = r_frame_lines;
  assign o_fmt_err     = r_fmt_err;

endmodule

// File: tb/tb_tft_timing_rx.sv
// Directed bench for tft_timing_rx on a scaled 24x9 format (16x6 active) with a pixel scoreboard.
module tb_tft_timing_rx;

  localparam int H_ACT = 16;
  localparam int V_ACT = 6;
  localparam int H_TOT = 24;
  localparam int V_TOT = 9;
  localparam int HSW   = 2;
  localparam int HBP   = 4;
  localparam int VSW   = 1;
  localparam int VBP   = 2;

  typedef struct packed {
    logic        valid;
    logic [10:0] x;
    logic [8:0]  y;
    logic        sof;
    logic        eol;
  } vidOut_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pixStb = 1'b0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        de = 1'b0;
  logic [10:0] x;
  logic [8:0]  y;
  logic        valid, sof, eol, locked, fmtErr;
  logic [10:0] lineTotal, frameLines;
`ifdef TFT_TIMING_RX_ERRCNT_EN
  logic [15:0] errCnt;
`endif

  int checks = 0;
  int errors = 0;
  int stride = 1;
  int mX, mY;
  bit mPrevDe, mPrevVs, mSofPend;
  int eolCount, sofCount;
  int errPulses = 0;
  bit lockBefore, lockFirst;
  vidOut_t expQ[$];

  tft_timing_rx #(
    .HS_ACTIVE_LOW(1), .VS_ACTIVE_LOW(1), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT),
    .CNT_W(11), .LOCK_FRAMES(2)
  ) dut (
    .i_clk(clock), .i_rst(reset), .i_pix_stb(pixStb),
    .i_hs(hs), .i_vs(vs), .i_de(de),
    .o_x(x), .o_y(y), .o_valid(valid), .o_sof(sof), .o_eol(eol),
    .o_locked(locked), .o_line_total(lineTotal), .o_frame_lines(frameLines),
    .o_fmt_err(fmtErr)
`ifdef TFT_TIMING_RX_ERRCNT_EN
    ,
    .o_err_cnt(errCnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mX = 0; mY = 0;
    mPrevDe = 1'b0; mPrevVs = 1'b0; mSofPend = 1'b0;
    expQ.delete();
  endtask

  // One strobe: predict the pixel outputs from the generator position, drive, then score.
  task automatic applyStimulus(input bit hsA, input bit vsA, input bit deA, input int px, input int ln);
    vidOut_t e, got;
    if (vsA && !mPrevVs) mSofPend = 1'b1;
    if (deA) begin
      mX = px;
      mY = (ln > V_ACT - 1) ? V_ACT - 1 : ln;
    end
    e.valid = deA;
    e.x     = 11'(mX);
    e.y     = 9'(mY);
    e.sof   = deA && mSofPend;
    e.eol   = mPrevDe && !deA;
    if (deA) mSofPend = 1'b0;
    mPrevDe = deA;
    mPrevVs = vsA;
    expQ.push_back(e);

    hs = ~hsA; vs = ~vsA; de = deA; pixStb = 1'b1;
    @(posedge clock); #1;
    pixStb = 1'b0;
    got = {valid, x, y, sof, eol};
    e = expQ.pop_front();
    checkOutput("video", got, e);
    eolCount  += int'(eol);
    sofCount  += int'(sof);
    errPulses += int'(fmtErr);
    for (int c = 1; c < stride; c++) begin
      @(posedge clock); #1;
      if (e.sof || e.eol) checkOutput("pulseHold", {sof, eol}, {e.sof, e.eol});
    end
  endtask

  task automatic runFrame(input int deLines, input int badLine, input int badWidth, input int maxStrobes);
    int n, w;
    bit hsA, vsA, deA;
    n = 0;
    lockBefore = locked;
    eolCount = 0;
    sofCount = 0;
    for (int l = 0; l < V_TOT; l++) begin
      for (int p = 0; p < H_TOT; p++) begin
        if (maxStrobes >= 0 && n >= maxStrobes) return;
        w   = (l - VBP == badLine) ? badWidth : H_ACT;
        hsA = (p < HSW);
        vsA = (l < VSW);
        deA = (l >= VBP) && (l < VBP + deLines) && (p >= HBP) && (p < HBP + w);
        applyStimulus(hsA, vsA, deA, p - HBP, l - VBP);
        if (n == 0) lockFirst = locked;
        n++;
      end
    end
  endtask

  task automatic releaseReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    resetModel();
  endtask

  initial begin
    resetModel();
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstAll", {x, y, valid, sof, eol, locked, lineTotal, frameLines, fmtErr}, 64'd0);
    reset = 1'b0;

    runFrame(V_ACT, -1, 0, -1);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("lineTotal", lineTotal, 64'd24);
    checkOutput("frameLines", frameLines, 64'd9);
    checkOutput("lockF2", lockFirst, 64'd0);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("lockF3", lockFirst, 64'd0);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("lockBeforeF4", lockBefore, 64'd0);
    checkOutput("lockRise", lockFirst, 64'd1);
    checkOutput("eolPerFrame", eolCount, 64'd6);
    checkOutput("sofPerFrame", sofCount, 64'd1);
    checkOutput("noErrYet", errPulses, 64'd0);

    runFrame(V_ACT, 3, H_ACT - 1, -1);
    checkOutput("fmtErrWidth", errPulses, 64'd1);
    checkOutput("unlockWidth", locked, 64'd0);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("searchF6", lockFirst, 64'd0);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("measureF7", lockFirst, 64'd0);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("relockWidth", lockFirst, 64'd1);
    checkOutput("noErrInSearch", errPulses, 64'd1);

    stride = 3;
    reset = 1'b1;
    releaseReset();
    runFrame(V_ACT, -1, 0, -1);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("lineTotalS3", lineTotal, 64'd24);
    checkOutput("frameLinesS3", frameLines, 64'd9);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("lockF3S3", lockFirst, 64'd0);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("lockRiseS3", {lockBefore, lockFirst}, 64'd1);
    checkOutput("eolPerFrameS3", eolCount, 64'd6);

    runFrame(V_ACT, -1, 0, 3 * H_TOT + 10);
    checkOutput("lockedBeforeRst", locked, 64'd1);
`ifdef TFT_TIMING_RX_ERRCNT_EN
    checkOutput("errCntBeforeRst", errCnt, 64'd1);
`endif
    reset = 1'b1;
    #2;
    checkOutput("asyncRst", {x, y, valid, sof, eol, locked, lineTotal, frameLines, fmtErr}, 64'd0);
`ifdef TFT_TIMING_RX_ERRCNT_EN
    checkOutput("errCntRst", errCnt, 64'd0);
`endif
    stride = 1;
    releaseReset();
    runFrame(V_ACT, -1, 0, -1);
    runFrame(V_ACT, -1, 0, -1);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("relockRstF3", lockFirst, 64'd0);
    runFrame(V_ACT, -1, 0, -1);
    checkOutput("relockRstF4", lockFirst, 64'd1);

    runFrame(V_ACT + 1, -1, 0, -1);
    checkOutput("eolTallFrame", eolCount, 64'd7);
    checkOutput("tallKeepsLock", {locked, 32'(errPulses)}, {1'b1, 32'd1});

    for (int s = 0; s < 2100; s++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
      if (s == 2000) checkOutput("noEarlySat", errPulses, 64'd1);
    end
    checkOutput("satErr", errPulses, 64'd2);
    checkOutput("unlockSat", locked, 64'd0);
`ifdef TFT_TIMING_RX_ERRCNT_EN
    checkOutput("errCntSat", errCnt, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tft_timing_rx.md
Name: tft_timing_rx

Overview:
- Receiving end of the 800x480 TFT timing interface: consumes HS/VS/DE from an upstream timing source and recovers pixel coordinates and frame markers.
- Measures line and frame totals and declares lock once the format is stable and matches the expected active size.
- Used for loopback checking of the panel timing generator and to sync capture/overlay logic to an external video source.

Parameters:
- HS_ACTIVE_LOW, 1, HS polarity (1 = active low).
- VS_ACTIVE_LOW, 1, VS polarity (1 = active low).
- H_ACTIVE, 800, expected DE-high pixels per line.
- V_ACTIVE, 480, expected DE lines per frame.
- CNT_W, 11, width of the line/frame total counters.
- LOCK_FRAMES, 2, consecutive matching frames required for lock (1..15).

Ports:
- i_clk  in  1  base clock.
- i_rst  in  1  asynchronous active-high reset.
- i_pix_stb  in  1  pixel strobe; all inputs are sampled only when high.
- i_hs  in  1  horizontal sync.
- i_vs  in  1  vertical sync.
- i_de  in  1  data enable.
- o_x  out  11  active pixel x.
- o_y  out  9  active line y.
- o_valid  out  1  o_x/o_y refer to an active pixel.
- o_sof  out  1  one-strobe pulse on the first active pixel of a frame.
- o_eol  out  1  one-strobe pulse on the DE falling edge.
- o_locked  out  1  format locked.
- o_line_total  out  CNT_W  last measured strobes per line.
- o_frame_lines  out  CNT_W  last measured lines per frame.
- o_fmt_err  out  1  one-strobe pulse on a lock-breaking mismatch.

Behaviour:
- Reset: all outputs and counters are 0; FSM is SEARCH. Reset mid-frame discards all measurements.
- All state advances only on i_clk edges with i_pix_stb=1. Between strobes, state holds and pulses remain high for exactly one strobe period.
- HS/VS are normalised to active-high per the polarity parameters.
- Leading/trailing edges are detected against the previous strobe's sample. Initial previous value is deasserted.
- h_cnt increments every strobe and saturates at all-ones. On an HS leading edge:
  - o_line_total <= h_cnt + 1.
  - h_cnt <= 0.
- v_cnt counts HS leading edges. On a VS leading edge:
  - o_frame_lines <= v_cnt.
  - v_cnt <= 0, or 1 if an HS edge coincides (that line belongs to the new frame).
- x_cnt increments while DE is high and clears on the DE falling edge.
- y_cnt increments on each DE falling edge and clears on the VS leading edge.
- o_x, o_y, o_valid are registered with 1-strobe latency from the DE sample:
  - o_valid = registered DE.
  - o_y saturates at V_ACTIVE-1.
- o_sof: first DE-high strobe after a VS edge, aligned with o_valid.
- o_eol: aligned with the first strobe where o_valid drops.
- Lock FSM:
  - SEARCH: wait for a VS leading edge, then go to MEASURE.
  - MEASURE: at each VS edge, compare o_line_total, o_frame_lines, last line width (x_cnt at DE fall) and DE line count.
    - A frame matches when line total and frame lines equal the previous frame's values and widths/heights equal H_ACTIVE/V_ACTIVE.
    - A match counter reaching LOCK_FRAMES moves to LOCKED with o_locked=1.
    - Any non-matching frame resets the match counter.
  - LOCKED:
    - Any DE line width != H_ACTIVE, line total change, or frame lines change pulses o_fmt_err and returns to SEARCH with o_locked=0.
    - h_cnt saturating (sync lost) does the same.
- In SEARCH, o_fmt_err is never pulsed.

Optional Feature:
- Macro TFT_TIMING_RX_ERRCNT_EN.
- Defined: adds output o_err_cnt (16 bit), incremented on every o_fmt_err pulse. It saturates at 0xFFFF and is cleared only by i_rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package tft_timing_pkg holds:
  - default H_ACTIVE/V_ACTIVE constants;
  - the FSM state enum (SEARCH, MEASURE, LOCKED);
  - the lock-counter width.
- Sub-module tft_sync_edge: polarity normalise, previous-sample register, leading/trailing pulse outputs, gated by strobe. It is instantiated for HS, VS and DE.

Test Plan:
- Stable 1056-strobe line, 525-line frame, 800-pixel DE over 480 lines, strobe every cycle:
  - o_line_total=1056 and o_frame_lines=525 after the first full frame;
  - o_locked rises at the VS edge ending frame 3.
- Locked stream: o_x runs 0..799 and o_eol pulses once per line; o_sof coincides with o_x=0, o_y=0; o_y runs 0..479.
- Locked, one line with DE high for 799 strobes -> o_fmt_err pulses once, o_locked=0, FSM SEARCH; relock after the following frames.
- HS stops toggling -> h_cnt saturates at 2047, o_fmt_err pulses, o_locked=0.
- i_pix_stb high every 3rd cycle -> identical counts and lock timing in strobe units; pulses last 3 cycles.
- Assert i_rst asynchronously mid-line while locked:
  - all outputs 0 immediately, before the next clock edge;
  - relock takes LOCK_FRAMES+1 frames after release;
  - with TFT_TIMING_RX_ERRCNT_EN defined, o_err_cnt clears to 0.
